// File: rtl/enemy_path_sched.sv
// enemy_path_sched: shares one enemy-path ROM among N_ENEMY slots, sweeping live slots once per movement tick.
// Optional ENEMY_Y_ROM_EN adds rom_y_data; otherwise every slot sits on the fixed Y_BASE row.
module enemy_path_sched #(
   parameter int N_ENEMY      = 4,
   parameter int TICK_LIMIT   = 1000000,
   parameter int LEVEL_SCALER = 150,
   parameter int MAX_LEVEL    = 3,
   parameter int PHASE_STEP   = 30,
   parameter int Y_BASE       = 100
) (
   input  logic                   pclk,
   input  logic                   rst,
   input  logic [3:0]             level,
   input  logic                   start,
   input  logic                   stop,
   input  logic [N_ENEMY-1:0]     enemy_alive,
   output logic [11:0]            rom_addr,
   input  logic [10:0]            rom_x_data,
`ifdef ENEMY_Y_ROM_EN
   input  logic [10:0]            rom_y_data,
`endif
   output logic [N_ENEMY*11-1:0]  xpos_flat,
   output logic [N_ENEMY*11-1:0]  ypos_flat,
   output logic                   frame_valid,
   output logic                   busy,
   output logic [7:0]             loop_cnt
);
   localparam int TW = $clog2(TICK_LIMIT);
   localparam int IW = $clog2(N_ENEMY + 1);
   typedef enum logic [1:0] {IDLE, RUN, SWEEP} state_t;
   state_t r_state, w_state_nxt;
   logic [TW-1:0]         r_tick;
   logic [IW-1:0]         r_idx, w_ci, w_ni;
   logic [N_ENEMY*12-1:0] r_ptr;
   logic [11:0]           r_base, w_base, w_cur, w_top, w_adv;
   logic [3:0]            w_lvl;
   logic                  r_issue_alive, w_tick_end, w_cap, w_last, w_load, w_more;
   always_comb begin
      w_tick_end  = r_tick == TW'(TICK_LIMIT - 1);
      w_cap       = r_state == SWEEP && r_idx != '0;
      w_last      = r_state == SWEEP && r_idx == IW'(N_ENEMY);
      w_more      = r_idx < IW'(N_ENEMY - 1);
      w_load      = r_state == IDLE && start && !stop;
      w_lvl       = level == 4'd0 ? 4'd1 : level > 4'(MAX_LEVEL) ? 4'(MAX_LEVEL) : level;
      w_base      = 12'(LEVEL_SCALER) * (12'(w_lvl) - 12'd1);
      w_ci        = w_cap ? r_idx - IW'(1) : '0;
      w_ni        = w_more ? r_idx + IW'(1) : '0;
      w_cur       = r_ptr[12*w_ci +: 12];
      w_top       = r_base + 12'(LEVEL_SCALER - 1);
      w_adv       = w_cur == w_top ? r_base : w_cur + 12'd1;
      w_state_nxt = stop ? IDLE :
                    w_load ? RUN :
                    (r_state == RUN && w_tick_end) ? SWEEP :
                    w_last ? RUN : r_state;
   end
   always_ff @(posedge pclk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end
   always_ff @(posedge pclk) begin
      if (rst) begin
         rom_addr      <= '0;
         xpos_flat     <= '0;
         ypos_flat     <= '0;
         loop_cnt      <= '0;
         frame_valid   <= 1'b0;
         busy          <= 1'b0;
         r_tick        <= '0;
         r_ptr         <= '0;
         r_base        <= '0;
         r_idx         <= '0;
         r_issue_alive <= 1'b0;
      end else begin
         frame_valid <= w_last && !stop;
         busy        <= w_state_nxt != IDLE;
         r_tick      <= (r_state == IDLE || w_tick_end) ? '0 : r_tick + TW'(1);
         if (w_load) begin
            r_base   <= w_base;
            loop_cnt <= '0;
            for (int i = 0; i < N_ENEMY; i++) begin
               r_ptr[12*i +: 12] <= w_base + 12'((i * PHASE_STEP) % LEVEL_SCALER);
`ifndef ENEMY_Y_ROM_EN
               ypos_flat[11*i +: 11] <= 11'(Y_BASE);
`endif
            end
         end
         if (r_state == RUN && w_tick_end && !stop) begin
            r_idx    <= '0;
            rom_addr <= r_ptr[11:0];
         end
         if (r_state == SWEEP) begin
            r_idx         <= r_idx + IW'(1);
            r_issue_alive <= |(enemy_alive & (N_ENEMY'(1) << r_idx));
            if (w_more) rom_addr <= r_ptr[12*w_ni +: 12];
         end
         // data fetched before a stop still lands; only later slots are abandoned
         if (w_cap && r_issue_alive) begin
            xpos_flat[11*w_ci +: 11] <= rom_x_data;
`ifdef ENEMY_Y_ROM_EN
            ypos_flat[11*w_ci +: 11] <= rom_y_data;
`endif
            r_ptr[12*w_ci +: 12] <= w_adv;
            if (w_ci == '0 && w_cur == w_top && loop_cnt != 8'hFF) loop_cnt <= loop_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_enemy_path_sched.sv
// tb_enemy_path_sched: directed scoreboard bench for enemy_path_sched with an identity ROM.
module tb_enemy_path_sched;
   logic        pclk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
   logic [3:0]  level = 4'd0, alive = 4'hF;
   logic [11:0] rom_addr;
   logic [10:0] rom_x_data;
`ifdef ENEMY_Y_ROM_EN
   logic [10:0] rom_y_data;
`endif
   logic [43:0] xpos_flat, ypos_flat;
   logic        frame_valid, busy;
   logic [7:0]  loop_cnt;
   int errors = 0, checks = 0, lat, seen;
   int m_ptr[4], m_x[4], m_y[4], m_base, m_loop;
   typedef struct {logic [43:0] x; logic [43:0] y; logic [7:0] l;} exp_t;
   exp_t q[$];

   enemy_path_sched #(.N_ENEMY(4), .TICK_LIMIT(10)) dut (
      .pclk(pclk), .rst(rst), .level(level), .start(start), .stop(stop),
      .enemy_alive(alive), .rom_addr(rom_addr), .rom_x_data(rom_x_data),
`ifdef ENEMY_Y_ROM_EN
      .rom_y_data(rom_y_data),
`endif
      .xpos_flat(xpos_flat), .ypos_flat(ypos_flat), .frame_valid(frame_valid),
      .busy(busy), .loop_cnt(loop_cnt));

   always #5 pclk = ~pclk;
   always @(posedge pclk) begin
      rom_x_data <= rom_addr[10:0];
`ifdef ENEMY_Y_ROM_EN
      rom_y_data <= rom_addr[10:0];
`endif
   end

   function automatic logic [43:0] pk(input int a, input int b, input int c, input int d);
      return {11'(d), 11'(c), 11'(b), 11'(a)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_start(input int lvl);
      int l;
      l = lvl == 0 ? 1 : lvl > 3 ? 3 : lvl;
      m_base = 150 * (l - 1);
      m_loop = 0;
      for (int i = 0; i < 4; i++) begin
         m_ptr[i] = m_base + (i * 30) % 150;
`ifndef ENEMY_Y_ROM_EN
         m_y[i] = 100;
`endif
      end
   endtask

   task automatic m_adv(input int i);
      m_x[i] = m_ptr[i];
`ifdef ENEMY_Y_ROM_EN
      m_y[i] = m_ptr[i];
`endif
      if (m_ptr[i] == m_base + 149) begin
         if (i == 0 && m_loop < 255) m_loop++;
         m_ptr[i] = m_base;
      end else m_ptr[i]++;
   endtask

   task automatic push_frame(input logic [3:0] a);
      exp_t e;
      for (int i = 0; i < 4; i++) if (a[i]) m_adv(i);
      e.x = pk(m_x[0], m_x[1], m_x[2], m_x[3]);
      e.y = pk(m_y[0], m_y[1], m_y[2], m_y[3]);
      e.l = 8'(m_loop);
      q.push_back(e);
   endtask

   task automatic wait_frame(output int n);
      exp_t e;
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge pclk); #1;
         if (frame_valid) begin n = c; break; end
      end
      chk("frame_seen", frame_valid, 1);
      chk("sb_nonempty", q.size() > 0, 1);
      if (frame_valid && q.size() > 0) begin
         e = q.pop_front();
         chk("frame_x", xpos_flat, e.x);
         chk("frame_y", ypos_flat, e.y);
         chk("frame_loop", loop_cnt, e.l);
      end
   endtask

   task automatic do_start(input logic [3:0] lvl);
      level = lvl; start = 1'b1;
      @(posedge pclk); #1 start = 1'b0;
      m_start(int'(lvl));
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(posedge pclk); #1 stop = 1'b0;
   endtask

   task automatic chk_reset_state();
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_x", xpos_flat, 0);
      chk("rst_y", ypos_flat, 0);
      chk("rst_loop", loop_cnt, 0);
      chk("rst_fv", frame_valid, 0);
      chk("rst_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin m_x[i] = 0; m_y[i] = 0; end
      m_loop = 0;
   endtask

   initial begin
      repeat (2) @(posedge pclk);
      #1 rst = 1'b0;
      chk_reset_state();
      do_start(4'd2);
      level = 4'd3;
      chk("busy_after_start", busy, 1);
      push_frame(4'hF); wait_frame(lat);
      chk("first_latency", lat, 15);
      chk("l2_x_first", xpos_flat, pk(150, 180, 210, 240));
      @(posedge pclk); #1;
      chk("fv_one_cycle", frame_valid, 0);
      push_frame(4'hF); wait_frame(lat);
      chk("frame_period", lat + 1, 10);
      chk("l2_x_second", xpos_flat, pk(151, 181, 211, 241));
      alive = 4'b1011;
      push_frame(alive); wait_frame(lat);
      push_frame(alive); wait_frame(lat);
      chk("dead_slot_frozen", xpos_flat[32:22], 211);
      alive = 4'hF;
      push_frame(alive); wait_frame(lat);
      chk("slot2_resumes", xpos_flat[32:22], 212);
      pulse_stop();
      chk("busy_after_stop", busy, 0);
      do_start(4'd0);
      push_frame(4'hF); wait_frame(lat);
      chk("lvl0_as_1", xpos_flat, pk(0, 30, 60, 90));
      pulse_stop();
      do_start(4'd9);
      push_frame(4'hF); wait_frame(lat);
      chk("lvl9_as_3", xpos_flat, pk(300, 330, 360, 390));
      pulse_stop();
      do_start(4'd1);
      for (int f = 1; f <= 150; f++) begin
         push_frame(4'hF); wait_frame(lat);
         if (f == 60) chk("x3_at_top", xpos_flat[43:33], 149);
         if (f == 61) chk("x3_wrapped", xpos_flat[43:33], 0);
      end
      chk("loop_cnt_one", loop_cnt, 1);
      repeat (7) @(posedge pclk);
      #1 stop = 1'b1;
      @(posedge pclk); #1 stop = 1'b0;
      m_adv(0); m_adv(1);
      chk("stop_busy", busy, 0);
      chk("stop_fv", frame_valid, 0);
      chk("stop_x", xpos_flat, pk(m_x[0], m_x[1], m_x[2], m_x[3]));
      chk("stop_loop", loop_cnt, m_loop);
      seen = 0;
      for (int c = 0; c < 20; c++) begin @(posedge pclk); #1 if (frame_valid) seen++; end
      chk("no_fv_after_stop", seen, 0);
      stop = 1'b1; start = 1'b1;
      @(posedge pclk); #1 begin stop = 1'b0; start = 1'b0; end
      chk("stop_wins_busy", busy, 0);
      seen = 0;
      for (int c = 0; c < 20; c++) begin @(posedge pclk); #1 if (frame_valid || busy) seen++; end
      chk("stays_idle", seen, 0);
      do_start(4'd2);
      push_frame(4'hF); wait_frame(lat);
      repeat (6) @(posedge pclk);
      #1 rst = 1'b1;
      @(posedge pclk); #1 rst = 1'b0;
      chk_reset_state();
      do_start(4'd1);
      chk("y_after_start", ypos_flat, pk(m_y[0], m_y[1], m_y[2], m_y[3]));
      push_frame(4'hF); wait_frame(lat);
      push_frame(4'hF); wait_frame(lat);
      chk("post_rst_x", xpos_flat, pk(1, 31, 61, 91));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
